// File: rtl/cthulhu_pkg.sv
// Shared definitions for the party manager: register codes, status layout and status bit indices.
package cthulhu_pkg;

  localparam logic [3:0] REG_MAX_HP   = 4'h1;
  localparam logic [3:0] REG_CUR_HP   = 4'h2;
  localparam logic [3:0] REG_MAX_SAN  = 4'h3;
  localparam logic [3:0] REG_CUR_SAN  = 4'h4;
  localparam logic [3:0] REG_DAMAGE   = 4'h5;
  localparam logic [3:0] REG_HEAL     = 4'h6;
  localparam logic [3:0] REG_HORROR   = 4'h7;
  localparam logic [3:0] REG_EXPOSE   = 4'h8;
  localparam logic [3:0] REG_STATUS   = 4'hC;
  localparam logic [3:0] REG_IRQ_PEND = 4'hD;

  localparam int ST_DEAD      = 0;
  localparam int ST_WOUNDED   = 1;
  localparam int ST_HEALTHY   = 2;
  localparam int ST_MAD       = 3;
  localparam int ST_GOING_MAD = 4;
  localparam int ST_SANE      = 5;

  // Packed MSB-first, so dead lands on bit 0 and sane on bit 5.
  typedef struct packed {
    logic sane;
    logic going_mad;
    logic mad;
    logic healthy;
    logic wounded;
    logic dead;
  } status_st;

endpackage

// File: rtl/cthulhu_party_manager_if.sv
// Register bus with read-data handshake between a host (master) and the party manager (slave).
interface cthulhu_party_manager_if #(
   parameter int ADDR_W = 12,
   parameter int STAT_W = 8
);
   logic [ADDR_W-1:0] addr;
   logic              write_en;
   logic              valid;
   logic              ready;
   logic [STAT_W-1:0] data_w;
   logic              rready;
   logic              rvalid;
   logic [STAT_W-1:0] data_r;

   modport master (
      output addr, write_en, valid, data_w, rready,
      input  ready, rvalid, data_r
   );

   modport slave (
      input  addr, write_en, valid, data_w, rready,
      output ready, rvalid, data_r
   );
endinterface

// File: rtl/cthulhu_char_core.sv
// One investigator: saturating life/sanity arithmetic, exposure drain and registered status.
// Optional sticky event flag under CTHULHU_EVENT_IRQ_EN.
module cthulhu_char_core
   import cthulhu_pkg::*;
#(
   parameter int STAT_W       = 8,
   parameter int DRAIN_PERIOD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [3:0]        wr_code,
   input  logic [STAT_W-1:0] wr_data,
   output logic [STAT_W-1:0] max_hp,
   output logic [STAT_W-1:0] cur_hp,
   output logic [STAT_W-1:0] max_san,
   output logic [STAT_W-1:0] cur_san,
   output logic              expose,
   output status_st          status
`ifdef CTHULHU_EVENT_IRQ_EN
   ,
   output logic              irq_flag
`endif
);

   localparam int CNT_W = $clog2(DRAIN_PERIOD);

   typedef struct packed {
      logic [STAT_W-1:0] max;
      logic [STAT_W-1:0] cur;
   } stat_t;

   stat_t            hp_q, hp_d, san_q, san_d;
   logic             expose_q, expose_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   status_st         status_q, status_d;
   logic [STAT_W:0]  heal_sum;
   logic [5:0]       st_bits;
   logic             tick, san_wr;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      hp_d     = hp_q;
      san_d    = san_q;
      expose_d = expose_q;
      cnt_d    = '0;
      tick     = 1'b0;
      heal_sum = {1'b0, hp_q.cur} + {1'b0, wr_data};
      san_wr   = wr_en && (wr_code == REG_MAX_SAN || wr_code == REG_CUR_SAN ||
                           wr_code == REG_HORROR);

      if (expose_q && san_q.cur != '0) begin
         if (cnt_q == CNT_W'(DRAIN_PERIOD - 1)) tick = 1'b1;
         else                                  cnt_d = cnt_q + 1'b1;
      end
      // A host sanity write on the tick edge wins; the decrement is dropped.
      if (tick && !san_wr) san_d.cur = san_q.cur - 1'b1;

      if (wr_en) begin
         case (wr_code)
            REG_MAX_HP: begin
               hp_d.max = wr_data;
               if (hp_q.cur > wr_data) hp_d.cur = wr_data;
            end
            REG_CUR_HP:  hp_d.cur = (wr_data > hp_q.max) ? hp_q.max : wr_data;
            REG_MAX_SAN: begin
               san_d.max = wr_data;
               san_d.cur = (san_q.cur > wr_data) ? wr_data : san_q.cur;
            end
            REG_CUR_SAN: san_d.cur = (wr_data > san_q.max) ? san_q.max : wr_data;
            REG_DAMAGE:  hp_d.cur  = (hp_q.cur > wr_data) ? hp_q.cur - wr_data : '0;
            REG_HORROR:  san_d.cur = (san_q.cur > wr_data) ? san_q.cur - wr_data : '0;
            REG_HEAL: begin
               if (hp_q.cur != '0)
                  hp_d.cur = (heal_sum > {1'b0, hp_q.max}) ? hp_q.max : heal_sum[STAT_W-1:0];
            end
            REG_EXPOSE:  expose_d = wr_data[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      st_bits               = '0;
      st_bits[ST_DEAD]      = (hp_q.cur == '0);
      st_bits[ST_WOUNDED]   = !st_bits[ST_DEAD] && (hp_q.cur < (hp_q.max >> 1));
      st_bits[ST_HEALTHY]   = !st_bits[ST_DEAD] && !st_bits[ST_WOUNDED];
      st_bits[ST_MAD]       = (san_q.cur == '0);
      st_bits[ST_GOING_MAD] = !st_bits[ST_MAD] && (san_q.cur <= (san_q.max >> 1));
      st_bits[ST_SANE]      = !st_bits[ST_MAD] && !st_bits[ST_GOING_MAD];
      status_d              = status_st'(st_bits);
   end

   // NOTE: all state is reset here; these are a handful of flops, not a memory array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hp_q     <= '0;
         san_q    <= '0;
         expose_q <= 1'b0;
         cnt_q    <= '0;
         status_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         hp_q     <= hp_d;
         san_q    <= san_d;
         expose_q <= expose_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

`ifdef CTHULHU_EVENT_IRQ_EN
   logic prev_dead_q, prev_mad_q, flag_q, rise, clr;

   assign rise = (status_q[ST_DEAD] && !prev_dead_q) || (status_q[ST_MAD] && !prev_mad_q);
   assign clr  = wr_en && (wr_code == REG_IRQ_PEND) && wr_data[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_dead_q <= 1'b0;
         prev_mad_q  <= 1'b0;
         flag_q      <= 1'b0;
      end else begin
         prev_dead_q <= status_q[ST_DEAD];
         prev_mad_q  <= status_q[ST_MAD];
         flag_q      <= rise ? 1'b1 : (clr ? 1'b0 : flag_q);
      end
   end

   assign irq_flag = flag_q;
`endif

   assign max_hp  = hp_q.max;
   assign cur_hp  = hp_q.cur;
   assign max_san = san_q.max;
   assign cur_san = san_q.cur;
   assign expose  = expose_q;
   assign status  = status_q;

endmodule

// File: rtl/cthulhu_party_manager.sv
// Party manager top: address decode, read mux and read-data handshake over NUM_CHAR character cores.
// Optional irq output and IRQ_PEND register under CTHULHU_EVENT_IRQ_EN.
module cthulhu_party_manager
   import cthulhu_pkg::*;
#(
   parameter int NUM_CHAR     = 4,
   parameter int STAT_W       = 8,
   parameter int ADDR_W       = 12,
   parameter int DRAIN_PERIOD = 16
) (
   input logic clk,
   input logic rst_n,
   cthulhu_party_manager_if.slave bus
`ifdef CTHULHU_EVENT_IRQ_EN
   ,
   output logic irq
`endif
);

   logic [3:0]        code;
   logic [7:0]        idx;
   logic              accept;
   logic [STAT_W-1:0] rd_val;
   logic              rvalid_q;
   logic [STAT_W-1:0] data_r_q;

   logic [STAT_W-1:0] max_hp  [NUM_CHAR];
   logic [STAT_W-1:0] cur_hp  [NUM_CHAR];
   logic [STAT_W-1:0] max_san [NUM_CHAR];
   logic [STAT_W-1:0] cur_san [NUM_CHAR];
   logic              expose  [NUM_CHAR];
   status_st          status  [NUM_CHAR];
`ifdef CTHULHU_EVENT_IRQ_EN
   logic [NUM_CHAR-1:0] flags;
   assign irq = |flags;
`endif

   assign code      = bus.addr[11:8];
   assign idx       = bus.addr[7:0];
   assign bus.ready = !rvalid_q || bus.rready;
   assign accept    = bus.valid && bus.ready;

   for (genvar g = 0; g < NUM_CHAR; g++) begin : g_char
      cthulhu_char_core #(
         .STAT_W       (STAT_W),
         .DRAIN_PERIOD (DRAIN_PERIOD)
      ) u_core (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (accept && bus.write_en && (idx == 8'(g))),
         .wr_code  (code),
         .wr_data  (bus.data_w),
         .max_hp   (max_hp[g]),
         .cur_hp   (cur_hp[g]),
         .max_san  (max_san[g]),
         .cur_san  (cur_san[g]),
         .expose   (expose[g]),
         .status   (status[g])
`ifdef CTHULHU_EVENT_IRQ_EN
         ,
         .irq_flag (flags[g])
`endif
      );
   end

   // Out-of-range indices match no core and fall through to zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_CHAR; i++) begin
         if (idx == 8'(i)) begin
            case (code)
               REG_MAX_HP:   rd_val = max_hp[i];
               REG_CUR_HP:   rd_val = cur_hp[i];
               REG_MAX_SAN:  rd_val = max_san[i];
               REG_CUR_SAN:  rd_val = cur_san[i];
               REG_EXPOSE:   rd_val = STAT_W'(expose[i]);
               REG_STATUS:   rd_val = STAT_W'(status[i]);
`ifdef CTHULHU_EVENT_IRQ_EN
               REG_IRQ_PEND: rd_val = STAT_W'(flags[i]);
`endif
               default:      rd_val = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         data_r_q <= '0;
      end else if (accept && !bus.write_en) begin
         rvalid_q <= 1'b1;
         data_r_q <= rd_val;
      end else if (rvalid_q && bus.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.data_r = data_r_q;

endmodule

// File: tb/tb_cthulhu_party_manager.sv
// Directed bench for cthulhu_party_manager: vector table plus drain, handshake, irq and reset sequences.
module tb_cthulhu_party_manager;
   import cthulhu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   cthulhu_party_manager_if #(.ADDR_W(12), .STAT_W(8)) bus ();
`ifdef CTHULHU_EVENT_IRQ_EN
   logic irq;
`endif

   cthulhu_party_manager #(
      .NUM_CHAR(4), .STAT_W(8), .ADDR_W(12), .DRAIN_PERIOD(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef CTHULHU_EVENT_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [3:0] code;
      logic [7:0] idx;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] code, input logic [7:0] idx, input logic [7:0] d);
      bus.addr = {code, idx}; bus.write_en = 1'b1; bus.data_w = d; bus.valid = 1'b1;
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] code, input logic [7:0] idx, output logic [8:0] got);
      bus.addr = {code, idx}; bus.write_en = 1'b0; bus.valid = 1'b1; bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      got = {bus.rvalid, bus.data_r};
   endtask

   task automatic rd_check(input string name, input logic [3:0] code, input logic [7:0] idx,
                           input logic [7:0] exp);
      logic [8:0] got;
      rd(code, idx, got);
      check(name, 32'(got), {23'd0, 1'b1, exp});
   endtask

   initial begin
      rst_n = 1'b0;
      bus.addr = '0; bus.write_en = 1'b0; bus.valid = 1'b0; bus.data_w = '0; bus.rready = 1'b0;
      #23;
      check("reset_rvalid", 32'(bus.rvalid), 0);
      check("reset_data_r", 32'(bus.data_r), 0);
      check("reset_ready",  32'(bus.ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycles(1);

      // wr, code, idx, data, expected read value
      vecs.push_back('{1'b1, REG_MAX_HP,  8'd2, 8'd100, 8'h00});
      vecs.push_back('{1'b1, REG_CUR_HP,  8'd2, 8'd40,  8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd2, 8'd0,   8'd40});
      vecs.push_back('{1'b0, REG_STATUS,  8'd2, 8'd0,   8'h0A});
      vecs.push_back('{1'b1, REG_CUR_HP,  8'd2, 8'd50,  8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd2, 8'd0,   8'd50});
      vecs.push_back('{1'b0, REG_STATUS,  8'd2, 8'd0,   8'h0C});
      vecs.push_back('{1'b1, REG_CUR_HP,  8'd2, 8'd200, 8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd2, 8'd0,   8'd100});
      vecs.push_back('{1'b1, REG_MAX_HP,  8'd2, 8'd60,  8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd2, 8'd0,   8'd60});
      vecs.push_back('{1'b0, REG_MAX_HP,  8'd2, 8'd0,   8'd60});
      vecs.push_back('{1'b1, REG_MAX_HP,  8'd1, 8'd100, 8'h00});
      vecs.push_back('{1'b1, REG_CUR_HP,  8'd1, 8'd90,  8'h00});
      vecs.push_back('{1'b1, REG_HEAL,    8'd1, 8'd30,  8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd1, 8'd0,   8'd100});
      vecs.push_back('{1'b1, REG_DAMAGE,  8'd1, 8'd250, 8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd1, 8'd0,   8'd0});
      vecs.push_back('{1'b0, REG_STATUS,  8'd1, 8'd0,   8'h09});
      vecs.push_back('{1'b1, REG_HEAL,    8'd1, 8'd10,  8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd1, 8'd0,   8'd0});
      vecs.push_back('{1'b0, REG_DAMAGE,  8'd1, 8'd0,   8'd0});
      vecs.push_back('{1'b1, REG_CUR_HP,  8'd1, 8'd5,   8'h00});
      vecs.push_back('{1'b0, REG_CUR_HP,  8'd1, 8'd0,   8'd5});
      vecs.push_back('{1'b1, REG_MAX_SAN, 8'd3, 8'd10,  8'h00});
      vecs.push_back('{1'b1, REG_CUR_SAN, 8'd3, 8'd20,  8'h00});
      vecs.push_back('{1'b0, REG_CUR_SAN, 8'd3, 8'd0,   8'd10});
      vecs.push_back('{1'b1, REG_HORROR,  8'd3, 8'd4,   8'h00});
      vecs.push_back('{1'b0, REG_CUR_SAN, 8'd3, 8'd0,   8'd6});
      vecs.push_back('{1'b0, REG_STATUS,  8'd3, 8'd0,   8'h21});
      vecs.push_back('{1'b1, REG_HORROR,  8'd3, 8'd100, 8'h00});
      vecs.push_back('{1'b0, REG_CUR_SAN, 8'd3, 8'd0,   8'd0});
      vecs.push_back('{1'b1, REG_CUR_SAN, 8'd3, 8'd5,   8'h00});
      vecs.push_back('{1'b0, REG_CUR_SAN, 8'd3, 8'd0,   8'd5});
      vecs.push_back('{1'b0, REG_STATUS,  8'd3, 8'd0,   8'h11});
      vecs.push_back('{1'b1, REG_MAX_SAN, 8'd3, 8'd3,   8'h00});
      vecs.push_back('{1'b0, REG_CUR_SAN, 8'd3, 8'd0,   8'd3});
      vecs.push_back('{1'b0, REG_MAX_SAN, 8'd3, 8'd0,   8'd3});
      vecs.push_back('{1'b1, 4'h9,        8'd0, 8'd55,  8'h00});
      vecs.push_back('{1'b0, 4'h9,        8'd0, 8'd0,   8'd0});
      vecs.push_back('{1'b1, REG_MAX_HP,  8'd7, 8'd5,   8'h00});
      vecs.push_back('{1'b0, REG_MAX_HP,  8'd7, 8'd0,   8'd0});
      vecs.push_back('{1'b0, REG_MAX_HP,  8'd0, 8'd0,   8'd0});
      vecs.push_back('{1'b1, REG_EXPOSE,  8'd0, 8'd3,   8'h00});
      vecs.push_back('{1'b0, REG_EXPOSE,  8'd0, 8'd0,   8'd1});
      vecs.push_back('{1'b1, REG_EXPOSE,  8'd0, 8'd0,   8'h00});
      vecs.push_back('{1'b0, REG_EXPOSE,  8'd0, 8'd0,   8'd0});

      foreach (vecs[i]) begin
         if (vecs[i].wr) wr(vecs[i].code, vecs[i].idx, vecs[i].data);
         else rd_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].idx, vecs[i].exp);
      end

      // Drain: exposure written on edge E0, ticks land on E0+16, +32, +48.
      wr(REG_MAX_SAN, 8'd0, 8'd10);
      wr(REG_CUR_SAN, 8'd0, 8'd3);
      wr(REG_EXPOSE,  8'd0, 8'd1);
      cycles(15);
      rd_check("drain_before_tick1", REG_CUR_SAN, 8'd0, 8'd3);
      rd_check("drain_after_tick1",  REG_CUR_SAN, 8'd0, 8'd2);
      cycles(30);
      rd_check("drain_before_tick3", REG_CUR_SAN, 8'd0, 8'd1);
      rd_check("drain_after_tick3",  REG_CUR_SAN, 8'd0, 8'd0);
      cycles(20);
      rd_check("drain_stays_zero",   REG_CUR_SAN, 8'd0, 8'd0);

      // Host write landing on the tick edge wins, and the counter restarts.
      wr(REG_CUR_SAN, 8'd0, 8'd8);
      cycles(15);
      wr(REG_CUR_SAN, 8'd0, 8'd7);
      rd_check("tick_write_wins",    REG_CUR_SAN, 8'd0, 8'd7);
      cycles(14);
      rd_check("restart_before_tick", REG_CUR_SAN, 8'd0, 8'd7);
      rd_check("restart_after_tick",  REG_CUR_SAN, 8'd0, 8'd6);
      wr(REG_EXPOSE, 8'd0, 8'd0);

      // Back-pressure, then back-to-back reads.
      bus.addr = {REG_CUR_HP, 8'd2}; bus.write_en = 1'b0; bus.valid = 1'b1; bus.rready = 1'b0;
      @(posedge clk); #1;
      check("bp_rvalid", 32'(bus.rvalid), 1);
      check("bp_ready",  32'(bus.ready), 0);
      check("bp_data",   32'(bus.data_r), 60);
      bus.addr = {REG_MAX_HP, 8'd2};
      @(posedge clk); #1;
      check("bp_hold_rvalid", 32'(bus.rvalid), 1);
      check("bp_hold_data",   32'(bus.data_r), 60);
      bus.rready = 1'b1;
      @(posedge clk); #1;
      check("b2b_1", {bus.rvalid, bus.data_r}, {1'b1, 8'd60});
      bus.addr = {REG_STATUS, 8'd2};
      @(posedge clk); #1;
      check("b2b_2", {bus.rvalid, bus.data_r}, {1'b1, 8'h0C});
      bus.valid = 1'b0;
      @(posedge clk); #1;
      check("b2b_drain", 32'(bus.rvalid), 0);

`ifdef CTHULHU_EVENT_IRQ_EN
      for (int c = 0; c < 4; c++) wr(REG_IRQ_PEND, 8'(c), 8'd1);
      cycles(2);
      check("irq_cleared", 32'(irq), 0);
      wr(REG_DAMAGE, 8'd1, 8'd255);
      check("irq_lat0", 32'(irq), 0);
      cycles(1);
      check("irq_lat1", 32'(irq), 0);
      cycles(1);
      check("irq_lat2", 32'(irq), 1);
      rd_check("irq_pend_set", REG_IRQ_PEND, 8'd1, 8'd1);
      wr(REG_IRQ_PEND, 8'd1, 8'd1);
      check("irq_after_clear", 32'(irq), 0);
      rd_check("irq_pend_clr", REG_IRQ_PEND, 8'd1, 8'd0);
`else
      rd_check("code_d_unmapped", REG_IRQ_PEND, 8'd0, 8'd0);
`endif

      // Reset while a read is still pending.
      bus.addr = {REG_CUR_HP, 8'd2}; bus.write_en = 1'b0; bus.valid = 1'b1; bus.rready = 1'b0;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      check("pend_rvalid", 32'(bus.rvalid), 1);
      #3 rst_n = 1'b0;
      #1;
      check("rst_rvalid", 32'(bus.rvalid), 0);
      check("rst_data_r", 32'(bus.data_r), 0);
      check("rst_ready",  32'(bus.ready), 1);
`ifdef CTHULHU_EVENT_IRQ_EN
      check("rst_irq", 32'(irq), 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_check("rst_cur_hp",  REG_CUR_HP,  8'd2, 8'd0);
      rd_check("rst_max_san", REG_MAX_SAN, 8'd3, 8'd0);
      rd_check("rst_max_hp",  REG_MAX_HP,  8'd1, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
